// File: rtl/serial_2_parallel_if.sv
// Parallel handshake and SPI pin bundle for the serial_2_parallel receiver.
// master is the receiver side, slave is the requester/peripheral side.
interface serial_2_parallel_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              busy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              spi_sck;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;

    modport master (
        input  start, tx_data, spi_miso,
        output busy, rx_data, rx_valid, spi_sck, spi_cs_n, spi_mosi
    );

    modport slave (
        output start, tx_data, spi_miso,
        input  busy, rx_data, rx_valid, spi_sck, spi_cs_n, spi_mosi
    );
endinterface

// File: rtl/serial_2_parallel.sv
// SPI mode-0 master: shifts a command out on mosi while reassembling a
// DATA_W-bit word from miso, then presents it with a one-cycle strobe.
module serial_2_parallel #(
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic clk,
    input  logic reset,
    serial_2_parallel_if.master bus
);
    localparam int MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNT_MAX = (CLK_DIV > MAX_SH) ? CLK_DIV : MAX_SH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            bus.busy     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            bus.spi_sck  <= 1'b0;
            bus.spi_cs_n <= 1'b1;
            bus.spi_mosi <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tx_sr        <= bus.tx_data;
                        bus.spi_mosi <= bus.tx_data[DATA_W-1];
                        bus.spi_cs_n <= 1'b0;
                        bus.busy     <= 1'b1;
                        cnt          <= '0;
                        bit_cnt      <= '0;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(CS_SETUP - 1)) begin
                        cnt   <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        cnt         <= '0;
                        bus.spi_sck <= ~bus.spi_sck;
                        if (!bus.spi_sck) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], bus.spi_miso};
                        end else if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            // last falling edge: park mosi low for the hold window
                            bus.spi_mosi <= 1'b0;
                            state        <= HOLD;
                        end else begin
                            bus.spi_mosi <= tx_sr[DATA_W-2];
                            tx_sr        <= {tx_sr[DATA_W-2:0], 1'b0};
                            bit_cnt      <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(CS_HOLD - 1)) begin
                        cnt          <= '0;
                        bus.spi_cs_n <= 1'b1;
                        bus.rx_data  <= rx_sr;
                        bus.rx_valid <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_2_parallel.sv
// Directed bench for serial_2_parallel: loopback, mode-0 slave, busy
// protection, back-to-back frames, mid-frame reset and a fast-divider build.
module tb_serial_2_parallel;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_2_parallel_if #(.DATA_W(16)) sif ();
    serial_2_parallel_if #(.DATA_W(16)) sif2 ();

    serial_2_parallel dut (.clk(clk), .reset(reset), .bus(sif));
    serial_2_parallel #(.DATA_W(16), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1))
        dut2 (.clk(clk), .reset(reset), .bus(sif2));

    int checks = 0;
    int errors = 0;

    // miso source for dut: 0 = loopback from mosi, 1 = mode-0 slave model
    int          mode = 0;
    logic [15:0] slv_sr = 16'h0;
    logic [15:0] slv_next = 16'h0;

    always_comb begin
        sif.spi_miso = 1'b0;
        case (mode)
            0:       sif.spi_miso = sif.spi_mosi;
            1:       sif.spi_miso = slv_sr[15];
            default: sif.spi_miso = 1'b0;
        endcase
    end

    // Bus monitor; sees register values from before the current edge.
    int          rise_cnt = 0;
    int          vld_cnt = 0;
    int          cs_low_cnt = 0;
    int          viol = 0;
    logic        sck_q = 1'b0;
    logic [15:0] mosi_sr = 16'h0;

    always @(posedge clk) begin
        if (!sck_q && sif.spi_sck) begin
            rise_cnt++;
            mosi_sr = {mosi_sr[14:0], sif.spi_mosi};
        end
        if (sif.rx_valid) vld_cnt++;
        if (!sif.spi_cs_n) cs_low_cnt++;
        if (sif.spi_cs_n && sif.spi_sck) viol++;
        // slave: loads while deselected, shifts after each sck falling edge
        if (sif.spi_cs_n) slv_sr <= slv_next;
        else if (sck_q && !sif.spi_sck) slv_sr <= {slv_sr[14:0], 1'b0};
        sck_q = sif.spi_sck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // returns at E0 + 1ns
    task automatic launch(input logic [15:0] tx);
        sif.tx_data = tx;
        sif.start   = 1'b1;
        step();
        sif.start   = 1'b0;
    endtask

    // cycles from the current point until rx_valid is seen, bounded
    task automatic wait_valid(output int n);
        n = 0;
        while (!sif.rx_valid && n < 400) begin
            step();
            n++;
        end
    endtask

    int n, n2, c0, v0, r0;

    initial begin
        sif.start    = 1'b0;
        sif.tx_data  = 16'h0;
        sif2.start   = 1'b0;
        sif2.tx_data = 16'h0;
        sif2.spi_miso = 1'b1;
        repeat (3) step();

        chk("rst_cs_n",  32'(sif.spi_cs_n), 1);
        chk("rst_sck",   32'(sif.spi_sck),  0);
        chk("rst_mosi",  32'(sif.spi_mosi), 0);
        chk("rst_busy",  32'(sif.busy),     0);
        chk("rst_valid", 32'(sif.rx_valid), 0);
        chk("rst_rx",    32'(sif.rx_data),  0);
        reset = 1'b0;
        repeat (2) step();

        // loopback
        mode = 0;
        c0 = cs_low_cnt;
        v0 = vld_cnt;
        launch(16'hA5C3);
        chk("lb_busy_e0", 32'(sif.busy),     1);
        chk("lb_cs_e0",   32'(sif.spi_cs_n), 0);
        chk("lb_mosi_e0", 32'(sif.spi_mosi), 1);
        wait_valid(n);
        chk("lb_latency", 32'(n), 132);
        chk("lb_rx",      32'(sif.rx_data), 32'h0000A5C3);
        chk("lb_busy_end", 32'(sif.busy), 0);
        step();
        chk("lb_valid_1cyc", 32'(sif.rx_valid), 0);
        chk("lb_cs_idle",    32'(sif.spi_cs_n), 1);
        repeat (2) step();
        chk("lb_cs_low_cycles", 32'(cs_low_cnt - c0), 132);
        chk("lb_valid_count",   32'(vld_cnt - v0), 1);

        // mode-0 slave
        mode = 1;
        slv_next = 16'h8001;
        repeat (2) step();
        r0 = rise_cnt;
        launch(16'h0000);
        wait_valid(n);
        chk("slv_latency", 32'(n), 132);
        chk("slv_rx",      32'(sif.rx_data), 32'h00008001);
        repeat (3) step();
        chk("slv_rises", 32'(rise_cnt - r0), 16);
        chk("slv_sck_cs_viol", 32'(viol), 0);

        // busy protection: second start at E0+50 is ignored
        mode = 0;
        v0 = vld_cnt;
        launch(16'h1234);
        repeat (49) step();
        sif.tx_data = 16'hFFFF;
        sif.start   = 1'b1;
        step();
        sif.start   = 1'b0;
        chk("bp_busy_mid", 32'(sif.busy), 1);
        wait_valid(n);
        chk("bp_latency", 32'(n), 82);
        chk("bp_rx",      32'(sif.rx_data), 32'h00001234);
        chk("bp_mosi",    32'(mosi_sr), 32'h00001234);
        repeat (150) step();
        chk("bp_valid_count", 32'(vld_cnt - v0), 1);
        chk("bp_cs_idle",     32'(sif.spi_cs_n), 1);

        // back-to-back with start held high
        mode = 1;
        slv_next = 16'h0001;
        repeat (2) step();
        sif.tx_data = 16'h0000;
        sif.start   = 1'b1;
        step();
        repeat (5) step();
        slv_next = 16'hFFFE;
        wait_valid(n);
        chk("b2b_lat1", 32'(n), 127);
        chk("b2b_rx1",  32'(sif.rx_data), 32'h00000001);
        chk("b2b_cs_hi", 32'(sif.spi_cs_n), 1);
        step();
        chk("b2b_cs_relow", 32'(sif.spi_cs_n), 0);
        chk("b2b_busy2",    32'(sif.busy), 1);
        wait_valid(n2);
        sif.start = 1'b0;
        chk("b2b_gap", 32'(n2 + 1), 133);
        chk("b2b_rx2", 32'(sif.rx_data), 32'h0000FFFE);
        step();
        chk("b2b_stop_cs",   32'(sif.spi_cs_n), 1);
        chk("b2b_stop_busy", 32'(sif.busy), 0);

        // reset mid-frame after a completed 0x5555 frame
        mode = 0;
        launch(16'h5555);
        wait_valid(n);
        chk("mr_prev_rx", 32'(sif.rx_data), 32'h00005555);
        step();
        v0 = vld_cnt;
        launch(16'h00FF);
        repeat (70) step();
        chk("mr_midframe_cs", 32'(sif.spi_cs_n), 0);
        reset = 1'b1;
        #1;
        chk("mr_cs",    32'(sif.spi_cs_n), 1);
        chk("mr_sck",   32'(sif.spi_sck),  0);
        chk("mr_busy",  32'(sif.busy),     0);
        chk("mr_rx",    32'(sif.rx_data),  0);
        chk("mr_mosi",  32'(sif.spi_mosi), 0);
        chk("mr_valid", 32'(sif.rx_valid), 0);
        step();
        reset = 1'b0;
        repeat (200) step();
        chk("mr_no_valid", 32'(vld_cnt - v0), 0);
        chk("mr_idle_cs",  32'(sif.spi_cs_n), 1);
        launch(16'h3C3C);
        wait_valid(n);
        chk("mr_next_latency", 32'(n), 132);
        chk("mr_next_rx",      32'(sif.rx_data), 32'h00003C3C);

        // fast build: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, miso held high
        sif2.tx_data = 16'h0000;
        sif2.start   = 1'b1;
        step();
        sif2.start   = 1'b0;
        chk("fast_busy_e0", 32'(sif2.busy), 1);
        n = 0;
        while (!sif2.rx_valid && n < 200) begin
            step();
            n++;
        end
        chk("fast_latency", 32'(n), 66);
        chk("fast_rx",      32'(sif2.rx_data), 32'h0000FFFF);
        step();
        chk("fast_cs_idle", 32'(sif2.spi_cs_n), 1);

        chk("sck_low_while_cs_high", 32'(viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
